// File: rtl/shift_right_sticky_if.sv
// Bundles the request and result signals of shift_right_sticky.
// The master side drives in/shift/inValid; the slave side returns out/sticky/stickyAnd.
interface shift_right_sticky_if #(
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int SHIFT_VAL_WIDTH = 3
);
    logic                       inValid;
    logic [IN_WIDTH-1:0]        in;
    logic [SHIFT_VAL_WIDTH-1:0] shift;
    logic                       outValid;
    logic [OUT_WIDTH-1:0]       out;
    logic                       sticky;
    logic                       stickyAnd;

    modport master (
        output inValid, in, shift,
        input  outValid, out, sticky, stickyAnd
    );

    modport slave (
        input  inValid, in, shift,
        output outValid, out, sticky, stickyAnd
    );
endinterface

// File: rtl/shift_right_sticky.sv
// Registered logical right shifter reporting OR/AND of every discarded input bit.
// Define SHIFT_RIGHT_STICKY_PIPE_EN to split the barrel shifter into two register stages.
module shift_right_sticky #(
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int SHIFT_VAL_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    shift_right_sticky_if.slave   bus
);
    localparam int W     = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int TRUNC = W - OUT_WIDTH;
    localparam int SPLIT = (SHIFT_VAL_WIDTH + 1) / 2;

    // mask marks which positions of data still hold real input bits (padding is 0)
    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic         st;
        logic         sa;
    } shState_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] out;
        logic                 st;
        logic                 sa;
    } shResult_t;

    function automatic shState_t initState(input logic [IN_WIDTH-1:0] inVal);
        shState_t r;
        r.data = '0;
        r.mask = '0;
        r.data[W-1 -: IN_WIDTH] = inVal;
        r.mask[W-1 -: IN_WIDTH] = '1;
        r.st = 1'b0;
        r.sa = 1'b1;
        return r;
    endfunction

    // Applies barrel stages lo..hi-1; each folds the bits it drops into st/sa.
    function automatic shState_t shiftStages(input shState_t s,
                                             input logic [SHIFT_VAL_WIDTH-1:0] amt,
                                             input int lo, input int hi);
        shState_t r;
        r = s;
        for (int k = 0; k < SHIFT_VAL_WIDTH; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                for (int i = 0; i < W; i++) begin
                    if (k >= 31 || i < (1 << k)) begin
                        r.st = r.st | r.data[i];
                        r.sa = r.sa & (r.data[i] | ~r.mask[i]);
                    end
                end
                if (k >= 31) begin
                    r.data = '0;
                    r.mask = '0;
                end else begin
                    r.data = r.data >> (1 << k);
                    r.mask = r.mask >> (1 << k);
                end
            end
        end
        return r;
    endfunction

    // Bits left below the output LSB are lost to truncation.
    function automatic shResult_t finishTrunc(input shState_t s);
        shResult_t r;
        r.st = s.st;
        r.sa = s.sa;
        for (int i = 0; i < TRUNC; i++) begin
            r.st = r.st | s.data[i];
            r.sa = r.sa & (s.data[i] | ~s.mask[i]);
        end
        r.out = s.data[W-1 -: OUT_WIDTH];
        return r;
    endfunction

`ifdef SHIFT_RIGHT_STICKY_PIPE_EN
    shState_t                   state_p0;
    shState_t                   state_p1;
    logic [SHIFT_VAL_WIDTH-1:0] amt_p1;
    logic                       vld_p1;
    shResult_t                  res_p1;
    shResult_t                  res_p2;
    logic                       vld_p2;

    always_comb begin
        state_p0 = shiftStages(initState(bus.in), bus.shift, 0, SPLIT);
    end

    // p0 -> p1: low shift bits applied
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            state_p1 <= '0;
            amt_p1   <= '0;
        end else begin
            vld_p1 <= bus.inValid;
            if (bus.inValid) begin
                state_p1 <= state_p0;
                amt_p1   <= bus.shift;
            end
        end
    end

    always_comb begin
        res_p1 = finishTrunc(shiftStages(state_p1, amt_p1, SPLIT, SHIFT_VAL_WIDTH));
    end

    // p1 -> p2: high shift bits and truncation applied
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= res_p1;
            end
        end
    end

    assign bus.outValid  = vld_p2;
    assign bus.out       = res_p2.out;
    assign bus.sticky    = res_p2.st;
    assign bus.stickyAnd = res_p2.sa;
`else
    shResult_t res_p0;
    shResult_t res_p1;
    logic      vld_p1;

    always_comb begin
        res_p0 = finishTrunc(shiftStages(initState(bus.in), bus.shift, 0, SHIFT_VAL_WIDTH));
    end

    // p0 -> p1: full shift and truncation applied
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else begin
            vld_p1 <= bus.inValid;
            if (bus.inValid) begin
                res_p1 <= res_p0;
            end
        end
    end

    assign bus.outValid  = vld_p1;
    assign bus.out       = res_p1.out;
    assign bus.sticky    = res_p1.st;
    assign bus.stickyAnd = res_p1.sa;
`endif
endmodule

// File: tb/tb_shift_right_sticky.sv
// Directed and random checks of shift_right_sticky over four width configurations.
// Honours SHIFT_RIGHT_STICKY_PIPE_EN by waiting the matching latency.
module tb_shift_right_sticky;
`ifdef SHIFT_RIGHT_STICKY_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NRAND = 80;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    shift_right_sticky_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(3)) if0 ();
    shift_right_sticky_if #(.IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(4)) if1 ();
    shift_right_sticky_if #(.IN_WIDTH(8), .OUT_WIDTH(4), .SHIFT_VAL_WIDTH(3)) if2 ();
    shift_right_sticky_if #(.IN_WIDTH(4), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(3)) if3 ();

    shift_right_sticky #(.IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(3))
        dut0 (.clock(clock), .reset(reset), .bus(if0));
    shift_right_sticky #(.IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(4))
        dut1 (.clock(clock), .reset(reset), .bus(if1));
    shift_right_sticky #(.IN_WIDTH(8), .OUT_WIDTH(4), .SHIFT_VAL_WIDTH(3))
        dut2 (.clock(clock), .reset(reset), .bus(if2));
    shift_right_sticky #(.IN_WIDTH(4), .OUT_WIDTH(8), .SHIFT_VAL_WIDTH(3))
        dut3 (.clock(clock), .reset(reset), .bus(if3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-bit reference: each input bit either lands in out or joins the discarded set.
    function automatic logic [33:0] model(input logic [31:0] inV, input int sh,
                                          input int inW, input int outW);
        int         w;
        int         pos;
        logic [31:0] o;
        logic       st;
        logic       sa;
        w  = (inW > outW) ? inW : outW;
        o  = '0;
        st = 1'b0;
        sa = 1'b1;
        for (int j = 0; j < inW; j++) begin
            pos = j + (w - inW) - sh;
            if (pos >= w - outW) o[pos - (w - outW)] = inV[j];
            else begin
                st = st | inV[j];
                sa = sa & inV[j];
            end
        end
        return {st, sa, o};
    endfunction

    task automatic checkDut0(input string tag, input logic v, input logic [7:0] o,
                             input logic s, input logic sa);
        check({tag, ".valid"}, 32'(if0.outValid), 32'(v));
        check({tag, ".out"}, 32'(if0.out), 32'(o));
        check({tag, ".sticky"}, 32'(if0.sticky), 32'(s));
        check({tag, ".stickyAnd"}, 32'(if0.stickyAnd), 32'(sa));
    endtask

    task automatic checkDut1(input string tag, input logic [7:0] o, input logic s, input logic sa);
        check({tag, ".valid"}, 32'(if1.outValid), 32'd1);
        check({tag, ".out"}, 32'(if1.out), 32'(o));
        check({tag, ".sticky"}, 32'(if1.sticky), 32'(s));
        check({tag, ".stickyAnd"}, 32'(if1.stickyAnd), 32'(sa));
    endtask

    task automatic checkDut2(input string tag, input logic [3:0] o, input logic s, input logic sa);
        check({tag, ".valid"}, 32'(if2.outValid), 32'd1);
        check({tag, ".out"}, 32'(if2.out), 32'(o));
        check({tag, ".sticky"}, 32'(if2.sticky), 32'(s));
        check({tag, ".stickyAnd"}, 32'(if2.stickyAnd), 32'(sa));
    endtask

    task automatic checkDut3(input string tag, input logic [7:0] o, input logic s, input logic sa);
        check({tag, ".valid"}, 32'(if3.outValid), 32'd1);
        check({tag, ".out"}, 32'(if3.out), 32'(o));
        check({tag, ".sticky"}, 32'(if3.sticky), 32'(s));
        check({tag, ".stickyAnd"}, 32'(if3.stickyAnd), 32'(sa));
    endtask

    task automatic applyAll(input logic [7:0] i0, input logic [2:0] s0,
                            input logic [7:0] i1, input logic [3:0] s1,
                            input logic [7:0] i2, input logic [2:0] s2,
                            input logic [3:0] i3, input logic [2:0] s3);
        @(negedge clock);
        if0.inValid = 1'b1; if0.in = i0; if0.shift = s0;
        if1.inValid = 1'b1; if1.in = i1; if1.shift = s1;
        if2.inValid = 1'b1; if2.in = i2; if2.shift = s2;
        if3.inValid = 1'b1; if3.in = i3; if3.shift = s3;
        repeat (LAT) @(posedge clock);
        #1;
    endtask

    logic        rstH [NRAND];
    logic        vH   [NRAND];
    logic [7:0]  in0H [NRAND];
    logic [2:0]  sh0H [NRAND];
    logic [7:0]  in2H [NRAND];
    logic [2:0]  sh2H [NRAND];

    initial begin
        logic        expV;
        logic [33:0] expD0;
        logic [33:0] expD2;
        logic        anyRst;
        int          src;

        reset = 1'b1;
        if0.inValid = 1'b0; if0.in = '0; if0.shift = '0;
        if1.inValid = 1'b0; if1.in = '0; if1.shift = '0;
        if2.inValid = 1'b0; if2.in = '0; if2.shift = '0;
        if3.inValid = 1'b0; if3.in = '0; if3.shift = '0;
        repeat (3) @(posedge clock);
        #1;
        checkDut0("reset0", 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset2.valid", 32'(if2.outValid), 32'd0);
        check("reset2.out", 32'(if2.out), 32'd0);
        check("reset3.stickyAnd", 32'(if3.stickyAnd), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        applyAll(8'hB4, 3'd3, 8'h80, 4'd12, 8'hA5, 3'd0, 4'hD, 3'd2);
        checkDut0("d0.b4s3", 1'b1, 8'h16, 1'b1, 1'b0);
        checkDut1("d1.80s12", 8'h00, 1'b1, 1'b0);
        checkDut2("d2.a5s0", 4'hA, 1'b1, 1'b0);
        checkDut3("d3.ds2", 8'h34, 1'b0, 1'b1);

        applyAll(8'hB4, 3'd0, 8'h00, 4'd15, 8'hBF, 3'd1, 4'hF, 3'd0);
        checkDut0("d0.b4s0", 1'b1, 8'hB4, 1'b0, 1'b1);
        checkDut1("d1.00s15", 8'h00, 1'b0, 1'b0);
        checkDut2("d2.bfs1", 4'h5, 1'b1, 1'b1);
        checkDut3("d3.fs0", 8'hF0, 1'b0, 1'b1);

        applyAll(8'hFF, 3'd7, 8'hFF, 4'd8, 8'hF0, 3'd7, 4'h9, 3'd7);
        checkDut0("d0.ffs7", 1'b1, 8'h01, 1'b1, 1'b1);
        checkDut1("d1.ffs8", 8'h00, 1'b1, 1'b1);
        checkDut2("d2.f0s7", 4'h0, 1'b1, 1'b0);
        checkDut3("d3.9s7", 8'h01, 1'b1, 1'b0);

        @(negedge clock);
        if0.inValid = 1'b0; if1.inValid = 1'b0; if2.inValid = 1'b0; if3.inValid = 1'b0;
        if0.in = 8'h00; if0.shift = 3'd0;
        repeat (LAT) @(posedge clock);
        #1;
        checkDut0("d0.idleHold", 1'b0, 8'h01, 1'b1, 1'b1);

        // Back-to-back random traffic with reset pulses at the start and mid-stream.
        expV  = 1'b0;
        expD0 = '0;
        expD2 = '0;
        for (int n = 0; n < NRAND; n++) begin
            @(negedge clock);
            rstH[n] = (n == 0) || (n == 37);
            vH[n]   = ($urandom_range(0, 3) != 0);
            in0H[n] = 8'($urandom_range(0, 255));
            sh0H[n] = 3'($urandom_range(0, 7));
            in2H[n] = 8'($urandom_range(0, 255));
            sh2H[n] = 3'($urandom_range(0, 7));
            reset = rstH[n];
            if0.inValid = vH[n]; if0.in = in0H[n]; if0.shift = sh0H[n];
            if2.inValid = vH[n]; if2.in = in2H[n]; if2.shift = sh2H[n];
            @(posedge clock);
            #1;
            src    = n - LAT + 1;
            anyRst = 1'b0;
            for (int m = (src < 0 ? 0 : src); m <= n; m++) anyRst = anyRst | rstH[m];
            if (rstH[n]) begin
                expV  = 1'b0;
                expD0 = '0;
                expD2 = '0;
            end else if (anyRst || src < 0) begin
                expV = 1'b0;
            end else if (vH[src]) begin
                expV  = 1'b1;
                expD0 = model(32'(in0H[src]), int'(sh0H[src]), 8, 8);
                expD2 = model(32'(in2H[src]), int'(sh2H[src]), 8, 4);
            end else begin
                expV = 1'b0;
            end
            check($sformatf("r0.valid@%0d", n), 32'(if0.outValid), 32'(expV));
            check($sformatf("r0.out@%0d", n), 32'(if0.out), expD0[31:0]);
            check($sformatf("r0.sticky@%0d", n), 32'(if0.sticky), 32'(expD0[33]));
            check($sformatf("r0.stickyAnd@%0d", n), 32'(if0.stickyAnd), 32'(expD0[32]));
            check($sformatf("r2.valid@%0d", n), 32'(if2.outValid), 32'(expV));
            check($sformatf("r2.out@%0d", n), 32'(if2.out), expD2[31:0]);
            check($sformatf("r2.sticky@%0d", n), 32'(if2.sticky), 32'(expD2[33]));
            check($sformatf("r2.stickyAnd@%0d", n), 32'(if2.stickyAnd), 32'(expD2[32]));
        end

        @(negedge clock);
        reset = 1'b0;
        if0.inValid = 1'b0;
        if2.inValid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
